// File: rtl/rf_wr_arb.sv
// rf_wr_arb: two-requester round-robin write arbiter for a register file
// write port, with an optional clear sequencer that zeroes every entry.
//
// Optional feature: define RF_WR_ARB_CLR_EN to compile in the clear
// sequencer. Without it i_clr_start is ignored and o_clr_busy/o_clr_done
// are tied to 0.
//
// Parameters:
//   BW_DATA  write data width
//   BW_ADDR  address width (2**BW_ADDR entries)
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_req0/1, i_addr0/1, i_data0/1 write requests (held until granted)
//   o_gnt0/1                      one-cycle grant per requester
//   i_clr_start                   pulse starting the clear sequence
//   o_clr_busy, o_clr_done        clear in progress / clear finished pulse
//   o_rf_wr_en/addr/data          registered register-file write port
module rf_wr_arb #(
  parameter int unsigned BW_DATA = 16,
  parameter int unsigned BW_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic [BW_ADDR-1:0] i_addr0,
  input  logic [BW_ADDR-1:0] i_addr1,
  input  logic [BW_DATA-1:0] i_data0,
  input  logic [BW_DATA-1:0] i_data1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  input  logic               i_clr_start,
  output logic               o_clr_busy,
  output logic               o_clr_done,
  output logic               o_rf_wr_en,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic [BW_DATA-1:0] o_rf_wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t state;
  logic   ptr;       // requester that wins when both are eligible
  logic   elig0;
  logic   elig1;
  logic   any_elig;
  logic   win1;

  // A requester whose grant is showing this cycle is masked so the same
  // held request is not written twice.
  always_comb begin
    elig0    = i_req0 & ~o_gnt0;
    elig1    = i_req1 & ~o_gnt1;
    any_elig = elig0 | elig1;
    win1     = elig1 & (~elig0 | ptr);
  end

`ifdef RF_WR_ARB_CLR_EN
  logic [BW_ADDR-1:0] clr_cnt;
  logic               clr_busy_q;
  logic               clr_done_q;

  assign o_clr_busy = clr_busy_q;
  assign o_clr_done = clr_done_q;
`else
  logic clr_start_unused;

  assign clr_start_unused = i_clr_start;
  assign o_clr_busy       = 1'b0;
  assign o_clr_done       = 1'b0;
`endif

  // Arbiter / clear FSM with registered write port and grants.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_IDLE;
      ptr          <= 1'b0;
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_addr <= '0;
      o_rf_wr_data <= '0;
`ifdef RF_WR_ARB_CLR_EN
      clr_cnt      <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
`endif
    end else begin
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_rf_wr_en <= 1'b0;
`ifdef RF_WR_ARB_CLR_EN
      clr_done_q <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_ARB: begin
`ifdef RF_WR_ARB_CLR_EN
          // Clear start wins over requests at the same edge; address 0 is
          // written right away and the counter points at the next entry.
          if (i_clr_start) begin
            state        <= ST_CLR;
            o_rf_wr_en   <= 1'b1;
            o_rf_wr_addr <= '0;
            o_rf_wr_data <= '0;
            clr_cnt      <= BW_ADDR'(1);
            clr_busy_q   <= 1'b1;
          end else
`endif
          if (any_elig) begin
            state        <= ST_ARB;
            ptr          <= ~win1;
            o_gnt0       <= ~win1;
            o_gnt1       <= win1;
            o_rf_wr_en   <= 1'b1;
            o_rf_wr_addr <= win1 ? i_addr1 : i_addr0;
            o_rf_wr_data <= win1 ? i_data1 : i_data0;
          end else begin
            state <= ST_IDLE;
          end
        end
`ifdef RF_WR_ARB_CLR_EN
        ST_CLR: begin
          // Counter wrapped to 0 after the last entry: finish the sequence.
          if (clr_cnt == '0) begin
            state      <= ST_IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            o_rf_wr_en   <= 1'b1;
            o_rf_wr_addr <= clr_cnt;
            o_rf_wr_data <= '0;
            clr_cnt      <= clr_cnt + BW_ADDR'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// tb_rf_wr_arb: scoreboard bench for rf_wr_arb (BW_DATA=16, BW_ADDR=4).
// Expected write-port/grant/clear outputs are queued as stimulus is driven
// and compared one cycle later, #1 after the rising edge.
module tb_rf_wr_arb;

  logic        clk;
  logic        rstn;
  logic        req0;
  logic        req1;
  logic [3:0]  addr0;
  logic [3:0]  addr1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        clr_start;
  logic        gnt0;
  logic        gnt1;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        en;
    logic        busy;
    logic        done;
    logic [3:0]  addr;
    logic [15:0] data;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  rf_wr_arb #(
    .BW_DATA(16),
    .BW_ADDR(4)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req0       (req0),
    .i_req1       (req1),
    .i_addr0      (addr0),
    .i_addr1      (addr1),
    .i_data0      (data0),
    .i_data1      (data1),
    .o_gnt0       (gnt0),
    .o_gnt1       (gnt1),
    .i_clr_start  (clr_start),
    .o_clr_busy   (clr_busy),
    .o_clr_done   (clr_done),
    .o_rf_wr_en   (wr_en),
    .o_rf_wr_addr (wr_addr),
    .o_rf_wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {gnt0, gnt1, wr_en, clr_busy, clr_done, wr_addr, wr_data};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Fields: g0 g1 en addr data busy done
  task automatic push_exp(input logic g0, input logic g1, input logic en,
                          input logic [3:0] a, input logic [15:0] d,
                          input logic busy, input logic done);
    obs_t e;
    e = {g0, g1, en, busy, done, a, d};
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(observe()), 32'(e));
    end
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    check_eq({tag, "_async"}, 32'(observe()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_held"}, 32'(observe()), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    addr0     = 4'd0;
    addr1     = 4'd0;
    data0     = 16'h0;
    data1     = 16'h0;
    clr_start = 1'b0;
    #2;
    do_reset("rst_init");

    // Single requester: grant one cycle later, then grant drops.
    req0  = 1'b1;
    addr0 = 4'd3;
    data0 = 16'h00A5;
    push_exp(1'b1, 1'b0, 1'b1, 4'd3, 16'h00A5, 1'b0, 1'b0);
    step("single_gnt");
    req0 = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd3, 16'h00A5, 1'b0, 1'b0);
    step("single_idle");

    // Contention from reset: 0,1,0,1 with continuous writes.
    do_reset("rst_cont");
    req0  = 1'b1;
    addr0 = 4'd1;
    data0 = 16'h1111;
    req1  = 1'b1;
    addr1 = 4'd2;
    data1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_exp(1'b1, 1'b0, 1'b1, 4'd1, 16'h1111, 1'b0, 1'b0);
      else            push_exp(1'b0, 1'b1, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0);
      step("cont");
    end
    req0 = 1'b0;
    req1 = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd2, 16'h2222, 1'b0, 1'b0);
    step("cont_idle");

    // Eligibility mask: single streaming requester every other cycle.
    req1  = 1'b1;
    addr1 = 4'd5;
    data1 = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_exp(1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0);
      else            push_exp(1'b0, 1'b0, 1'b0, 4'd5, 16'hBEEF, 1'b0, 1'b0);
      step("mask");
    end
    req1 = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd5, 16'hBEEF, 1'b0, 1'b0);
    step("mask_idle");

`ifdef RF_WR_ARB_CLR_EN
    // Clear with a request at the same edge; a second start mid-clear is ignored.
    clr_start = 1'b1;
    req0      = 1'b1;
    addr0     = 4'd9;
    data0     = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      push_exp(1'b0, 1'b0, 1'b1, 4'(i), 16'h0, 1'b1, 1'b0);
      step("clr_wr");
      clr_start = (i == 4);
    end
    push_exp(1'b0, 1'b0, 1'b0, 4'd15, 16'h0, 1'b0, 1'b1);
    step("clr_done");
    push_exp(1'b1, 1'b0, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b0);
    step("clr_then_gnt0");
    req0 = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd9, 16'h1234, 1'b0, 1'b0);
    step("clr_idle");

    // Reset during the write to address 7 (pointer is at 1 here).
    clr_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_exp(1'b0, 1'b0, 1'b1, 4'(i), 16'h0, 1'b1, 1'b0);
      step("clr2_wr");
      clr_start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    check_eq("rst_midclr_async", 32'(observe()), 32'd0);
    push_exp(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step("rst_midclr_hold");
    push_exp(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step("rst_midclr_hold");
    rstn = 1'b1;
`else
    // Without the clear sequencer the start pulse is ignored.
    clr_start = 1'b1;
    req0      = 1'b1;
    addr0     = 4'd9;
    data0     = 16'h1234;
    push_exp(1'b1, 1'b0, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b0);
    step("noclr_gnt");
    clr_start = 1'b0;
    req0      = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd9, 16'h1234, 1'b0, 1'b0);
    step("noclr_idle");
    do_reset("rst_ptr");
`endif

    // After reset: no done pulse, pointer back at requester 0, req1 served.
    push_exp(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step("post_rst_no_done");
    req0  = 1'b1;
    addr0 = 4'd6;
    data0 = 16'h0606;
    req1  = 1'b1;
    addr1 = 4'd7;
    data1 = 16'h0707;
    push_exp(1'b1, 1'b0, 1'b1, 4'd6, 16'h0606, 1'b0, 1'b0);
    step("ptr_rst_gnt0");
    req0 = 1'b0;
    push_exp(1'b0, 1'b1, 1'b1, 4'd7, 16'h0707, 1'b0, 1'b0);
    step("req1_served");
    req1 = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd7, 16'h0707, 1'b0, 1'b0);
    step("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 SHALL have parameter BW_DATA, default 16, data width of the register file write port.
REQ-002 SHALL have parameter BW_ADDR, default 4, register file address width (2**BW_ADDR entries).
REQ-003 SHALL have port i_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_req0 / i_req1  input  1  write request from requester 0 / 1.
REQ-006 SHALL have ports i_addr0 / i_addr1  input  BW_ADDR  write address from requester 0 / 1.
REQ-007 SHALL have ports i_data0 / i_data1  input  BW_DATA  write data from requester 0 / 1.
REQ-008 SHALL have ports o_gnt0 / o_gnt1  output  1  one-cycle grant (acknowledge) to requester 0 / 1.
REQ-009 SHALL have port i_clr_start  input  1  pulse that starts the clear sequence.
REQ-010 SHALL have port o_clr_busy  output  1  clear sequence in progress.
REQ-011 SHALL have port o_clr_done  output  1  one-cycle pulse when the clear sequence ends.
REQ-012 SHALL have ports o_rf_wr_en  output  1,  o_rf_wr_addr  output  BW_ADDR,  and o_rf_wr_data  output  BW_DATA.
- These three drive the register file write port.
- All three are registered.

Function
REQ-013 SHALL be an FSM with states IDLE, ARB and CLR.
- IDLE moves to ARB when any request is eligible.
- IDLE moves to CLR when i_clr_start=1.
- ARB returns to IDLE when no request is eligible.
REQ-014 SHALL define eligibility: requester k is eligible when i_reqk=1 and o_gntk=0 in the current cycle.
- This mask prevents a second write of data whose grant is being consumed.
REQ-015 SHALL, at each rising edge with at least one eligible requester and no clear active or starting:
- select one eligible requester as winner;
- register o_rf_wr_en=1, o_rf_wr_addr=i_addrk and o_rf_wr_data=i_datak of the winner;
- register o_gntk=1 for the winner.
REQ-016 SHALL use latency 1 cycle: the request is sampled at edge N, and the grant and write-port outputs are valid in the cycle following edge N.
REQ-017 SHALL require requesters to hold req/addr/data stable until grant; the requester may change them at the edge that ends the grant cycle.
REQ-018 SHALL arbitrate round-robin with a 1-bit priority pointer.
- If both are eligible, the pointer selects the winner.
- After every grant, the pointer moves to the other requester.
- A single eligible requester wins regardless of the pointer.
REQ-019 SHALL sustain one write per cycle when both requesters stream, alternating 0/1; a single streaming requester gets one write every 2 cycles.
REQ-020 SHALL drive o_gnt0, o_gnt1 and o_rf_wr_en to 0 in any cycle without a granted write.
- In those cycles o_rf_wr_addr and o_rf_wr_data hold their last values.
REQ-021 SHALL never assert o_gnt0 and o_gnt1 in the same cycle.

Reset
REQ-022 SHALL, while i_rstn=0, immediately force:
- state IDLE, priority pointer to requester 0, clear counter 0;
- o_gnt0, o_gnt1, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_clr_busy and o_clr_done all to 0.
REQ-023 SHALL, on reset asserted mid-clear, abort the sequence with no o_clr_done pulse; after release the state is IDLE.

Configuration
REQ-024 SHALL compile in the clear sequencer only when macro RF_WR_ARB_CLR_EN is defined.
REQ-025 SHALL, with RF_WR_ARB_CLR_EN defined, on i_clr_start=1 in IDLE or ARB, enter CLR at that edge; in CLR:
- write 0 to addresses 0..2**BW_ADDR-1, one per cycle in ascending order, with o_rf_wr_en=1;
- hold o_clr_busy=1 from the first clear write through the last;
- assert no grants.
REQ-026 SHALL, at the end of CLR, pulse o_clr_done one cycle after the write to address 2**BW_ADDR-1.
- The counter wraps to 0 and the FSM returns to IDLE.
- Pending requests are then served normally.
REQ-027 SHALL give i_clr_start priority over requests arriving at the same edge, and SHALL ignore i_clr_start while o_clr_busy=1.
REQ-028 SHALL, without RF_WR_ARB_CLR_EN:
- keep all ports present;
- ignore i_clr_start;
- tie o_clr_busy and o_clr_done to 0;
- never enter state CLR.

Verification
REQ-029 SHALL verify single requester:
- Stimulus: i_req0=1, i_addr0=3, i_data0=0x00A5 held.
- Response: o_gnt0=1, o_rf_wr_en=1, addr 3, data 0x00A5 one cycle later; o_gnt0=0 the next cycle.
REQ-030 SHALL verify contention:
- Stimulus: both requesters stream from reset, req0 addr 1 data 0x1111, req1 addr 2 data 0x2222.
- Response: grants alternate 0,1,0,1 in consecutive cycles with o_rf_wr_en=1 continuously.
REQ-031 SHALL verify the eligibility mask:
- Stimulus: i_req1 held high with constant addr 5 / data 0xBEEF; i_req0=0.
- Response: o_gnt1 pattern 1,0,1,0, and address 5 is written every other cycle only.
REQ-032 SHALL verify clear (macro defined, BW_ADDR=4):
- Stimulus: i_clr_start pulse with i_req0=1 at the same edge.
- Response: 16 writes of 0 to addresses 0..15 with o_clr_busy=1; then o_clr_done=1 for one cycle; then o_gnt0=1.
REQ-033 SHALL verify reset mid-clear:
- Stimulus: i_rstn=0 during the write to address 7.
- Response: all outputs 0 immediately; no o_clr_done pulse; after release, i_req1 is served with pointer reset to 0.
